// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: base opcodes, the canonical NOP, and the decoded control bundle.
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic reg_we;
    logic mem_re;
    logic mem_we;
    logic alu_imm;
  } ctrl_t;

endpackage

// File: rtl/instruction_decode_regfile.sv
// 32-entry integer register file: two combinational read ports with write-through,
// one synchronous write port, x0 reads as zero, whole array cleared by reset.
module regfile #(
  parameter int BW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [BW-1:0] rd1,
  output logic [BW-1:0] rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [BW-1:0] wd
);

  localparam int DEPTH = 1 << AW;

  logic [BW-1:0] mem [DEPTH];

  // NOTE: the array has an asynchronous clear, so it must be built from flops,
  // not a RAM macro; keep every entry in the reset branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && wa != '0) begin
      mem[wa] <= wd;
    end
  end

  // NOTE: outputs get a default before any condition so no latch is inferred.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) rd1 = (we && wa == ra1) ? wd : mem[ra1];
    if (ra2 != '0) rd2 = (we && wa == ra2) ? wd : mem[ra2];
  end

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: immediate generation, control decode, load-use hazard
// detection and the ID/EX pipeline register.
module instruction_decode
  import rv32i_pkg::*;
#(
  parameter int BW    = 32,
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BW-1:0]    id_instr,
  input  logic [BW-1:0]    id_pc,
  input  logic             flush,
  input  logic             wb_we,
  input  logic [RF_AW-1:0] wb_rd,
  input  logic [BW-1:0]    wb_data,
  output logic             stall,
  output logic [BW-1:0]    ex_pc,
  output logic [BW-1:0]    ex_rs1_data,
  output logic [BW-1:0]    ex_rs2_data,
  output logic [BW-1:0]    ex_imm,
  output logic [RF_AW-1:0] ex_rs1,
  output logic [RF_AW-1:0] ex_rs2,
  output logic [RF_AW-1:0] ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7b5,
  output logic [6:0]       ex_opcode,
  output logic             ex_reg_we,
  output logic             ex_mem_re,
  output logic             ex_mem_we,
  output logic             ex_alu_imm
);

  logic [6:0]       opcode;
  logic [RF_AW-1:0] rs1, rs2, rd;
  logic [BW-1:0]    rs1_data, rs2_data, imm;
  ctrl_t            ctrl, ex_ctrl;
  logic             uses_rs2, bubble;

  assign opcode = id_instr[6:0];
  assign rd     = id_instr[7 +: RF_AW];
  assign rs1    = id_instr[15 +: RF_AW];
  assign rs2    = id_instr[20 +: RF_AW];

  regfile #(.BW(BW), .AW(RF_AW)) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rs1_data),
    .rd2 (rs2_data),
    .we  (wb_we),
    .wa  (wb_rd),
    .wd  (wb_data)
  );

  always_comb begin
    imm      = '0;
    ctrl     = '0;
    uses_rs2 = 1'b0;
    unique case (opcode)
      OP_R: begin
        ctrl.reg_we = 1'b1;
        uses_rs2    = 1'b1;
      end
      OP_I, OP_LOAD, OP_JALR: begin
        imm          = {{20{id_instr[31]}}, id_instr[31:20]};
        ctrl.reg_we  = 1'b1;
        ctrl.alu_imm = 1'b1;
        ctrl.mem_re  = (opcode == OP_LOAD);
      end
      OP_STORE: begin
        imm          = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
        ctrl.mem_we  = 1'b1;
        ctrl.alu_imm = 1'b1;
        uses_rs2     = 1'b1;
      end
      OP_BRANCH: begin
        imm      = {{19{id_instr[31]}}, id_instr[31], id_instr[7], id_instr[30:25],
                    id_instr[11:8], 1'b0};
        uses_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm          = {id_instr[31:12], 12'b0};
        ctrl.reg_we  = 1'b1;
        ctrl.alu_imm = 1'b1;
      end
      OP_JAL: begin
        imm         = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12], id_instr[20],
                       id_instr[30:21], 1'b0};
        ctrl.reg_we = 1'b1;
      end
      default: ;
    endcase
  end

  // A load in EX cannot feed its data to the instruction in ID this cycle.
  assign stall  = ex_ctrl.mem_re && (ex_rd != '0) &&
                  ((ex_rd == rs1) || (uses_rs2 && ex_rd == rs2));
  assign bubble = stall || flush;

  // NOTE: pipeline state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
      ex_opcode   <= '0;
      ex_ctrl     <= '0;
    end else begin
      ex_pc <= id_pc;
      if (bubble) begin
        ex_rs1_data <= '0;
        ex_rs2_data <= '0;
        ex_imm      <= '0;
        ex_rs1      <= '0;
        ex_rs2      <= '0;
        ex_rd       <= '0;
        ex_funct3   <= '0;
        ex_funct7b5 <= 1'b0;
        ex_opcode   <= NOP_INSTR[6:0];
        ex_ctrl     <= '0;
      end else begin
        ex_rs1_data <= rs1_data;
        ex_rs2_data <= rs2_data;
        ex_imm      <= imm;
        ex_rs1      <= rs1;
        ex_rs2      <= rs2;
        ex_rd       <= rd;
        ex_funct3   <= id_instr[14:12];
        ex_funct7b5 <= id_instr[30];
        ex_opcode   <= opcode;
        ex_ctrl     <= ctrl;
      end
    end
  end

  assign ex_reg_we  = ex_ctrl.reg_we;
  assign ex_mem_re  = ex_ctrl.mem_re;
  assign ex_mem_we  = ex_ctrl.mem_we;
  assign ex_alu_imm = ex_ctrl.alu_imm;

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode: a reference model predicts stall and the
// ID/EX contents; a negedge monitor pops and compares whatever the DUT presents.
module tb_instruction_decode;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] id_instr = NOP_INSTR;
  logic [31:0] id_pc = '0;
  logic        flush = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        stall;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic [6:0]  ex_opcode;
  logic        ex_reg_we, ex_mem_re, ex_mem_we, ex_alu_imm;

  always #5 clk = ~clk;

  instruction_decode #(.BW(32), .RF_AW(5)) dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_pc(id_pc), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7b5(ex_funct7b5), .ex_opcode(ex_opcode), .ex_reg_we(ex_reg_we),
    .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we), .ex_alu_imm(ex_alu_imm)
  );

  typedef struct packed {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7b5;
    logic [6:0]  op;
    logic        reg_we, mem_re, mem_we, alu_imm;
  } ex_t;

  typedef struct { int due; logic val; } st_rec_t;
  typedef struct { int due; ex_t ex; } ex_rec_t;

  st_rec_t     st_q[$];
  ex_rec_t     ex_q[$];
  logic [31:0] rf_m [32];
  ex_t         ex_m = '0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_mis = 0;
  logic        st_obs, st_exp;
  logic [31:0] pc_ctr = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: format rules and control table straight from the ISA description.
  function automatic logic [3:0] ref_ctrl(input logic [6:0] op); // {reg_we, mem_re, mem_we, alu_imm}
    case (op)
      OP_R:               return 4'b1000;
      OP_I:               return 4'b1001;
      OP_LOAD:            return 4'b1101;
      OP_STORE:           return 4'b0011;
      OP_JAL:             return 4'b1000;
      OP_JALR:            return 4'b1001;
      OP_LUI, OP_AUIPC:   return 4'b1001;
      default:            return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    int si, top;
    si  = i;
    top = si >>> 31;
    case (i[6:0])
      OP_I, OP_LOAD, OP_JALR: return si >>> 20;
      OP_STORE:  return (si >>> 25) * 32 + int'(i[11:7]);
      OP_BRANCH: return top * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      OP_JAL:    return top * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
      OP_LUI, OP_AUIPC: return i & 32'hFFFF_F000;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] a, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'd0;
    if (we && wa == a) return wd;
    return rf_m[a];
  endfunction

  function automatic logic ref_stall(input logic [31:0] i);
    logic uses2;
    uses2 = (i[6:0] == OP_R) || (i[6:0] == OP_STORE) || (i[6:0] == OP_BRANCH);
    return ex_m.mem_re && ex_m.rd != 0 && (ex_m.rd == i[19:15] || (uses2 && ex_m.rd == i[24:20]));
  endfunction

  function automatic ex_t ref_ex(input logic [31:0] i, input logic [31:0] pc, input logic bub,
                                 input logic we, input logic [4:0] wa, input logic [31:0] wd);
    ex_t e;
    e = '0;
    e.pc = pc;
    if (bub) begin
      e.op = 7'h13;
    end else begin
      e.rs1d = rf_read(i[19:15], we, wa, wd);
      e.rs2d = rf_read(i[24:20], we, wa, wd);
      e.imm  = ref_imm(i);
      e.rs1  = i[19:15];
      e.rs2  = i[24:20];
      e.rd   = i[11:7];
      e.f3   = i[14:12];
      e.f7b5 = i[30];
      e.op   = i[6:0];
      {e.reg_we, e.mem_re, e.mem_we, e.alu_imm} = ref_ctrl(i[6:0]);
    end
    return e;
  endfunction

  // Called at posedge+1: drives one ID cycle, queues expectations, returns at next posedge+1.
  task automatic step(input logic [31:0] instr, input logic [31:0] pc, input logic fl,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    ex_t nx;
    id_instr = instr; id_pc = pc; flush = fl; wb_we = we; wb_rd = wa; wb_data = wd;
    st_exp = ref_stall(instr);
    st_q.push_back('{cyc, st_exp});
    nx = ref_ex(instr, pc, st_exp || fl, we, wa, wd);
    ex_q.push_back('{cyc + 1, nx});
    if (we && wa != 0) rf_m[wa] = wd;
    ex_m = nx;
    #1 st_obs = stall;
    @(posedge clk);
    #1;
  endtask

  task automatic iss(input logic [31:0] instr, input logic fl = 1'b0, input logic we = 1'b0,
                     input logic [4:0] wa = 5'd0, input logic [31:0] wd = 32'd0);
    step(instr, pc_ctr, fl, we, wa, wd);
    pc_ctr = pc_ctr + 32'd1;
  endtask

  task automatic check_reset_state();
    check("rst_ex_pc", ex_pc, 32'd0);
    check("rst_ex_rs1_data", ex_rs1_data, 32'd0);
    check("rst_ex_rs2_data", ex_rs2_data, 32'd0);
    check("rst_ex_imm", ex_imm, 32'd0);
    check("rst_ex_fields", 32'({ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, ex_opcode,
                                ex_reg_we, ex_mem_re, ex_mem_we, ex_alu_imm}), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
  endtask

  task automatic model_reset();
    st_q.delete();
    ex_q.delete();
    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    ex_m = '0;
    id_instr = NOP_INSTR; flush = 1'b0; wb_we = 1'b0; wb_rd = '0;
  endtask

  // Monitor: compares every queued expectation once its cycle arrives.
  st_rec_t s_rec;
  ex_rec_t e_rec;
  always @(negedge clk) begin
    if (rst) begin
      while (st_q.size() > 0 && st_q[0].due <= cyc) begin
        s_rec = st_q.pop_front();
        check("stall", 32'(stall), 32'(s_rec.val));
      end
      while (ex_q.size() > 0 && ex_q[0].due <= cyc) begin
        e_rec = ex_q.pop_front();
        check("ex_pc", ex_pc, e_rec.ex.pc);
        check("ex_rs1_data", ex_rs1_data, e_rec.ex.rs1d);
        check("ex_rs2_data", ex_rs2_data, e_rec.ex.rs2d);
        check("ex_imm", ex_imm, e_rec.ex.imm);
        check("ex_fields", 32'({ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, ex_opcode,
                                ex_reg_we, ex_mem_re, ex_mem_we, ex_alu_imm}),
              32'({e_rec.ex.rs1, e_rec.ex.rs2, e_rec.ex.rd, e_rec.ex.f3, e_rec.ex.f7b5,
                   e_rec.ex.op, e_rec.ex.reg_we, e_rec.ex.mem_re, e_rec.ex.mem_we,
                   e_rec.ex.alu_imm}));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no $finish, expected bench to end");
    $fatal(1);
  end

  logic [6:0]  ops [12];
  logic [31:0] r, ins;
  logic        rep, fl;
  logic        we;
  logic [4:0]  wa;

  initial begin
    ops = '{OP_R, OP_I, OP_LOAD, OP_LOAD, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, 7'b1111111};
    model_reset();
    #1 check_reset_state();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Read data from a prior write-back, I-type immediate.
    iss(NOP_INSTR, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    iss(32'hFFF2_8313);
    check("addi_rs1_data", ex_rs1_data, 32'hDEAD_BEEF);
    check("addi_imm", ex_imm, 32'hFFFF_FFFF);
    check("addi_rd", 32'(ex_rd), 32'd6);
    check("addi_reg_we", 32'(ex_reg_we), 32'd1);
    check("addi_alu_imm", 32'(ex_alu_imm), 32'd1);

    // Write-through and x0.
    iss(32'h0003_8433, 1'b0, 1'b1, 5'd7, 32'h0000_1234);
    check("wt_rs1_data", ex_rs1_data, 32'h0000_1234);
    iss(NOP_INSTR, 1'b0, 1'b1, 5'd0, 32'h0000_FFFF);
    iss(32'h0000_0433);
    check("x0_read", ex_rs1_data, 32'd0);

    // Load-use: one stall cycle, one bubble, then the add issues.
    iss(32'h0000_A483);
    iss(32'h0024_8533);
    check("lu_stall", 32'(st_obs), 32'd1);
    check("lu_bubble_reg_we", 32'(ex_reg_we), 32'd0);
    check("lu_bubble_rd", 32'(ex_rd), 32'd0);
    iss(32'h0024_8533);
    check("lu_stall_clear", 32'(st_obs), 32'd0);
    check("lu_issue_rs1", 32'(ex_rs1), 32'd9);
    check("lu_issue_rd", 32'(ex_rd), 32'd10);

    // Flush, and flush together with stall.
    iss(32'h0032_2423, 1'b1);
    check("flush_mem_we", 32'(ex_mem_we), 32'd0);
    check("flush_opcode", 32'(ex_opcode), 32'h13);
    iss(32'h0000_A483);
    iss(32'h0024_8533, 1'b1);
    check("fs_stall", 32'(st_obs), 32'd1);
    check("fs_opcode", 32'(ex_opcode), 32'h13);
    check("fs_reg_we", 32'(ex_reg_we), 32'd0);
    iss(32'h0024_8533);
    check("fs_single_bubble", 32'(ex_reg_we), 32'd1);

    // Immediate formats.
    iss(32'hFE20_8EE3);
    check("imm_b", ex_imm, 32'hFFFF_FFFC);
    iss(32'h0010_00EF);
    check("imm_j", ex_imm, 32'h0000_0800);
    iss(32'hABCD_E0B7);
    check("imm_u", ex_imm, 32'hABCD_E000);

    // Randomized traffic; a stalled instruction is re-presented like fetch would.
    rep = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!rep) begin
        r = $urandom();
        if ($urandom_range(0, 1) == 1) begin
          r[19:15] = 5'($urandom_range(0, 3));
          r[24:20] = 5'($urandom_range(0, 3));
          r[11:7]  = 5'($urandom_range(0, 3));
        end
        r[6:0] = ops[$urandom_range(0, 11)];
        ins = r;
        pc_ctr = pc_ctr + 32'd1;
      end
      fl = ($urandom_range(0, 9) == 0);
      we = 1'($urandom_range(0, 1));
      wa = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      step(ins, pc_ctr, fl, we, wa, $urandom());
      rep = st_exp && !fl;
    end

    // Populate every register, then reset mid-cycle and read them all back.
    for (int i = 1; i < 32; i++) iss(NOP_INSTR, 1'b0, 1'b1, 5'(i), $urandom() | 32'h1);
    #2 rst = 1'b0;
    #1 check_reset_state();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 1; i < 32; i++) begin
      ins = 32'h0000_0033;
      ins[19:15] = 5'(i);
      ins[24:20] = 5'(32 - i);
      iss(ins);
    end

    iss(NOP_INSTR);
    @(negedge clk);
    @(negedge clk);
    check("sb_drain", 32'(ex_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
